// File: rtl/mmu_pkg.sv
// Shared FSM state type, target encodings and watchdog sizing helper for mmu_port_router.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic TGT_MEM    = 1'b0;
    localparam logic TGT_PERIPH = 1'b1;

    function automatic int unsigned cntWidth(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mmu_port_router_arbiter.sv
// Combinational round-robin arbiter: ascending search from ptr, wrapping at NUM_PORTS.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    localparam int unsigned IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDXW-1:0]      ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDXW-1:0]      idx
);

    always_comb begin
        int unsigned k;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            k = (32'(ptr) + i) % NUM_PORTS;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IDXW'(k);
            end
        end
    end

endmodule

// File: rtl/mmu_port_router.sv
// Routes per-port transactions to the memory or peripheral target by address MSB.
// Optional watchdog enabled by defining MMU_TIMEOUT_EN.
module mmu_port_router
    import mmu_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            reqValid,
    input  logic [NUM_PORTS-1:0]            reqWrite,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] reqAddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] reqData,
    output logic [NUM_PORTS-1:0]            respValid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] respData,
    output logic [NUM_PORTS-1:0]            respError,
    output logic                            memValid,
    output logic                            memWrite,
    output logic [ADDR_WIDTH-1:0]           memAddr,
    output logic [DATA_WIDTH-1:0]           memWdata,
    input  logic                            memReady,
    input  logic [DATA_WIDTH-1:0]           memRdata,
    output logic                            perValid,
    output logic                            perWrite,
    output logic [ADDR_WIDTH-1:0]           perAddr,
    output logic [DATA_WIDTH-1:0]           perWdata,
    input  logic                            perReady,
    input  logic [DATA_WIDTH-1:0]           perRdata
);

    localparam int unsigned IDXW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned NT   = 2;

    state_t state     [NT];
    state_t stateNext [NT];

    logic [NT-1:0][NUM_PORTS-1:0]  tgtReq;
    logic [NT-1:0][NUM_PORTS-1:0]  arbGrant;
    logic [NT-1:0][NUM_PORTS-1:0]  grantOh;
    logic [NT-1:0][IDXW-1:0]       arbIdx;
    logic [NT-1:0][IDXW-1:0]       rrPtr;
    logic [NT-1:0]                 tgtValid;
    logic [NT-1:0]                 tgtWrite;
    logic [NT-1:0][ADDR_WIDTH-1:0] tgtAddr;
    logic [NT-1:0][DATA_WIDTH-1:0] tgtWdata;
    logic [NT-1:0]                 tgtReady;
    logic [NT-1:0][DATA_WIDTH-1:0] tgtRdata;
    logic [NT-1:0]                 toFire;
    logic [NT-1:0]                 done;
    logic [NUM_PORTS-1:0]          owned;

    logic [NUM_PORTS-1:0]            respValidNext;
    logic [NUM_PORTS-1:0]            respErrorNext;
    logic [NUM_PORTS*DATA_WIDTH-1:0] respDataNext;

    assign tgtReady[TGT_MEM]    = memReady;
    assign tgtReady[TGT_PERIPH] = perReady;
    assign tgtRdata[TGT_MEM]    = memRdata;
    assign tgtRdata[TGT_PERIPH] = perRdata;

    assign memValid = tgtValid[TGT_MEM];
    assign memWrite = tgtWrite[TGT_MEM];
    assign memAddr  = tgtAddr[TGT_MEM];
    assign memWdata = tgtWdata[TGT_MEM];
    assign perValid = tgtValid[TGT_PERIPH];
    assign perWrite = tgtWrite[TGT_PERIPH];
    assign perAddr  = tgtAddr[TGT_PERIPH];
    assign perWdata = tgtWdata[TGT_PERIPH];

    for (genvar t = 0; t < NT; t++) begin : gArb
        rr_arbiter #(.NUM_PORTS(NUM_PORTS)) uArb (
            .req   (tgtReq[t]),
            .ptr   (rrPtr[t]),
            .grant (arbGrant[t]),
            .idx   (arbIdx[t])
        );
    end

    // A port held by either target is hidden from both arbiters, so a changed
    // address while waiting cannot make the other target grant it too.
    always_comb begin
        logic route;
        owned  = '0;
        tgtReq = '0;
        route  = 1'b0;
        for (int unsigned t = 0; t < NT; t++)
            if (state[t] != IDLE) owned = owned | grantOh[t];
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            route = reqAddr[i*ADDR_WIDTH + ADDR_WIDTH - 1];
            tgtReq[route][i] = reqValid[i] & ~owned[i];
        end
    end

`ifdef MMU_TIMEOUT_EN
    localparam int unsigned CW = cntWidth(TIMEOUT_CYCLES);
    logic [NT-1:0][CW-1:0] toCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toCnt <= '0;
        end else begin
            for (int unsigned t = 0; t < NT; t++) begin
                if (state[t] == IDLE) toCnt[t] <= '0;
                else if (state[t] == BUSY) toCnt[t] <= toCnt[t] + 1'b1;
            end
        end
    end

    always_comb begin
        toFire = '0;
        for (int unsigned t = 0; t < NT; t++)
            toFire[t] = (state[t] == BUSY) && !tgtReady[t] &&
                        (toCnt[t] == CW'(TIMEOUT_CYCLES - 1));
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign toFire        = '0;
`endif

    always_comb begin
        done = '0;
        for (int unsigned t = 0; t < NT; t++) begin
            stateNext[t] = state[t];
            done[t]      = (state[t] == BUSY) && (tgtReady[t] || toFire[t]);
            unique case (state[t])
                IDLE:    if (|arbGrant[t]) stateNext[t] = BUSY;
                BUSY:    if (done[t]) stateNext[t] = DONE;
                DONE:    stateNext[t] = IDLE;
                default: stateNext[t] = IDLE;
            endcase
        end
    end

    always_comb begin
        respValidNext = '0;
        respErrorNext = '0;
        respDataNext  = '0;
        for (int unsigned t = 0; t < NT; t++) begin
            if (done[t]) begin
                respValidNext = respValidNext | grantOh[t];
                for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                    if (grantOh[t][i]) begin
                        respErrorNext[i] = ~tgtReady[t];
                        respDataNext[i*DATA_WIDTH +: DATA_WIDTH] =
                            (tgtWrite[t] || !tgtReady[t]) ? '0 : tgtRdata[t];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned t = 0; t < NT; t++) state[t] <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grantOh   <= '0;
            rrPtr     <= '0;
            tgtValid  <= '0;
            tgtWrite  <= '0;
            tgtAddr   <= '0;
            tgtWdata  <= '0;
            respValid <= '0;
            respError <= '0;
            respData  <= '0;
        end else begin
            respValid <= respValidNext;
            respError <= respErrorNext;
            respData  <= respDataNext;
            for (int unsigned t = 0; t < NT; t++) begin
                if (state[t] == IDLE && |arbGrant[t]) begin
                    grantOh[t]  <= arbGrant[t];
                    rrPtr[t]    <= (arbIdx[t] == IDXW'(NUM_PORTS - 1)) ? '0 : arbIdx[t] + 1'b1;
                    tgtValid[t] <= 1'b1;
                    tgtWrite[t] <= reqWrite[arbIdx[t]];
                    tgtAddr[t]  <= reqAddr[arbIdx[t]*ADDR_WIDTH +: ADDR_WIDTH];
                    tgtWdata[t] <= reqData[arbIdx[t]*DATA_WIDTH +: DATA_WIDTH];
                end else if (done[t]) begin
                    tgtValid[t] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmu_port_router.sv
// Directed self-checking bench for mmu_port_router (2 ports, 32-bit address/data).
module tb_mmu_port_router;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    reqValid, reqWrite;
    logic [NP*AW-1:0] reqAddr;
    logic [NP*DW-1:0] reqData;
    logic [NP-1:0]    respValid, respError;
    logic [NP*DW-1:0] respData;
    logic             memValid, memWrite, memReady;
    logic [AW-1:0]    memAddr;
    logic [DW-1:0]    memWdata, memRdata;
    logic             perValid, perWrite, perReady;
    logic [AW-1:0]    perAddr;
    logic [DW-1:0]    perWdata, perRdata;

    int unsigned nTests = 0;
    int unsigned nFail  = 0;

    always #5 clk = ~clk;

    mmu_port_router #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respData(respData), .respError(respError),
        .memValid(memValid), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata),
        .memReady(memReady), .memRdata(memRdata),
        .perValid(perValid), .perWrite(perWrite), .perAddr(perAddr), .perWdata(perWdata),
        .perReady(perReady), .perRdata(perRdata)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        reqValid = '0; reqWrite = '0; reqAddr = '0; reqData = '0;
        memReady = 1'b0; memRdata = '0; perReady = 1'b0; perRdata = '0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqValid = 2'b11; reqAddr = {32'h8000_0000, 32'h0000_0100}; memReady = 1'b1; perReady = 1'b1;
        step();
        step();
        nTests++; if (respValid !== 2'b00) begin nFail++; $display("FAIL reset_respValid got %b want 00", respValid); end
        nTests++; if (respData !== '0) begin nFail++; $display("FAIL reset_respData got %h want 0", respData); end
        nTests++; if (respError !== 2'b00) begin nFail++; $display("FAIL reset_respError got %b want 00", respError); end
        nTests++; if ({memValid, memWrite, perValid, perWrite} !== 4'b0000) begin nFail++; $display("FAIL reset_valids got %b want 0000", {memValid, memWrite, perValid, perWrite}); end
        nTests++; if ({memAddr, memWdata, perAddr, perWdata} !== '0) begin nFail++; $display("FAIL reset_fields got %h want 0", {memAddr, memWdata, perAddr, perWdata}); end
        idleInputs();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        doReset();
        reqValid = 2'b01; reqAddr[31:0] = 32'h0000_0100; memReady = 1'b1; memRdata = 32'hDEAD_BEEF;
        step();
        nTests++; if ({memValid, memWrite, perValid} !== 3'b100) begin nFail++; $display("FAIL read_c1_valid got %b want 100", {memValid, memWrite, perValid}); end
        nTests++; if (memAddr !== 32'h0000_0100) begin nFail++; $display("FAIL read_c1_addr got %h want 00000100", memAddr); end
        nTests++; if (respValid !== 2'b00) begin nFail++; $display("FAIL read_c1_resp got %b want 00", respValid); end
        step();
        nTests++; if (respValid !== 2'b01) begin nFail++; $display("FAIL read_c2_respValid got %b want 01", respValid); end
        nTests++; if (respData[31:0] !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL read_c2_data got %h want deadbeef", respData[31:0]); end
        nTests++; if (respError !== 2'b00) begin nFail++; $display("FAIL read_c2_err got %b want 00", respError); end
        nTests++; if (memValid !== 1'b0) begin nFail++; $display("FAIL read_c2_memValid got %b want 0", memValid); end
        reqValid = 2'b00;
        step();
        nTests++; if (respValid !== 2'b00) begin nFail++; $display("FAIL read_c3_resp got %b want 00", respValid); end
    endtask

    task automatic test_contention();
        doReset();
        reqValid = 2'b11; reqAddr = {32'h0000_0080, 32'h0000_0040}; memReady = 1'b1; memRdata = 32'h1111_1111;
        step();
        nTests++; if (memAddr !== 32'h0000_0040) begin nFail++; $display("FAIL cont_first_addr got %h want 00000040", memAddr); end
        step();
        nTests++; if (respValid !== 2'b01) begin nFail++; $display("FAIL cont_first_resp got %b want 01", respValid); end
        nTests++; if (respData[31:0] !== 32'h1111_1111) begin nFail++; $display("FAIL cont_first_data got %h want 11111111", respData[31:0]); end
        reqValid = 2'b10; memRdata = 32'h2222_2222;
        step();
        nTests++; if ({memValid, respValid} !== 3'b000) begin nFail++; $display("FAIL cont_idle got %b want 000", {memValid, respValid}); end
        step();
        nTests++; if ({memValid, memAddr} !== {1'b1, 32'h0000_0080}) begin nFail++; $display("FAIL cont_second_addr got %b/%h want 1/00000080", memValid, memAddr); end
        step();
        nTests++; if (respValid !== 2'b10) begin nFail++; $display("FAIL cont_second_resp got %b want 10", respValid); end
        nTests++; if (respData[63:32] !== 32'h2222_2222) begin nFail++; $display("FAIL cont_second_data got %h want 22222222", respData[63:32]); end
        reqValid = 2'b11;
        step();
        step();
        nTests++; if (memAddr !== 32'h0000_0040) begin nFail++; $display("FAIL cont_ptr_wrap got %h want 00000040", memAddr); end
        step();
        nTests++; if (respValid !== 2'b01) begin nFail++; $display("FAIL cont_third_resp got %b want 01", respValid); end
        idleInputs();
    endtask

    task automatic test_parallel();
        doReset();
        reqValid = 2'b11; reqAddr = {32'h8000_0004, 32'h0000_0010};
        memReady = 1'b1; perReady = 1'b1; memRdata = 32'hA5A5_A5A5; perRdata = 32'h5A5A_0001;
        step();
        nTests++; if ({memValid, perValid} !== 2'b11) begin nFail++; $display("FAIL par_valid got %b want 11", {memValid, perValid}); end
        nTests++; if ({memAddr, perAddr} !== {32'h0000_0010, 32'h8000_0004}) begin nFail++; $display("FAIL par_addr got %h/%h want 00000010/80000004", memAddr, perAddr); end
        step();
        nTests++; if (respValid !== 2'b11) begin nFail++; $display("FAIL par_resp got %b want 11", respValid); end
        nTests++; if (respData !== {32'h5A5A_0001, 32'hA5A5_A5A5}) begin nFail++; $display("FAIL par_data got %h want 5a5a0001a5a5a5a5", respData); end
        idleInputs();
    endtask

    task automatic test_write_wait();
        doReset();
        reqValid = 2'b10; reqWrite = 2'b10; reqAddr[63:32] = 32'h0000_0200; reqData[63:32] = 32'h1234_5678;
        memRdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 3; c++) begin
            step();
            nTests++; if ({memValid, memWrite, respValid} !== 4'b1100) begin nFail++; $display("FAIL wr_c%0d_ctrl got %b want 1100", c, {memValid, memWrite, respValid}); end
            nTests++; if ({memAddr, memWdata} !== {32'h0000_0200, 32'h1234_5678}) begin nFail++; $display("FAIL wr_c%0d_fields got %h/%h want 00000200/12345678", c, memAddr, memWdata); end
            if (c == 1) begin reqData[63:32] = 32'hBAD0_BAD0; reqAddr[63:32] = 32'h0000_0300; end
            if (c == 3) memReady = 1'b1;
        end
        step();
        nTests++; if ({respValid, respError} !== 4'b1000) begin nFail++; $display("FAIL wr_c4_resp got %b want 1000", {respValid, respError}); end
        nTests++; if (respData[63:32] !== 32'h0) begin nFail++; $display("FAIL wr_c4_data got %h want 0", respData[63:32]); end
        idleInputs();
    endtask

    task automatic test_back_to_back();
        logic [5:0] expResp;
        expResp = 6'b010010;
        doReset();
        reqValid = 2'b01; reqAddr[31:0] = 32'h0000_0020; memReady = 1'b1; memRdata = 32'h0000_0001;
        for (int c = 1; c <= 6; c++) begin
            step();
            nTests++; if (respValid[0] !== expResp[c-1]) begin nFail++; $display("FAIL b2b_c%0d got %b want %b", c, respValid[0], expResp[c-1]); end
            if (c == 2) memRdata = 32'h0000_0002;
            if (c == 5) begin
                nTests++; if (respData[31:0] !== 32'h0000_0002) begin nFail++; $display("FAIL b2b_data got %h want 2", respData[31:0]); end
            end
        end
        idleInputs();
    endtask

    task automatic test_timeout();
        doReset();
        reqValid = 2'b10; reqAddr[63:32] = 32'h8000_0000; perRdata = 32'h0000_0077;
`ifdef MMU_TIMEOUT_EN
        for (int c = 1; c <= 255; c++) begin
            step();
            nTests++; if ({perValid, respValid} !== 3'b100) begin nFail++; $display("FAIL to_wait_c%0d got %b want 100", c, {perValid, respValid}); end
        end
        step();
        nTests++; if ({respValid, respError} !== 4'b1010) begin nFail++; $display("FAIL to_resp got %b want 1010", {respValid, respError}); end
        nTests++; if ({perValid, respData[63:32]} !== 33'h0) begin nFail++; $display("FAIL to_data got %b/%h want 0/0", perValid, respData[63:32]); end
`else
        for (int c = 1; c <= 300; c++) begin
            step();
            nTests++; if ({perValid, respValid, respError} !== 5'b10000) begin nFail++; $display("FAIL nto_wait_c%0d got %b want 10000", c, {perValid, respValid, respError}); end
        end
        perReady = 1'b1;
        step();
        nTests++; if ({respValid, respError} !== 4'b1000) begin nFail++; $display("FAIL nto_resp got %b want 1000", {respValid, respError}); end
        nTests++; if (respData[63:32] !== 32'h0000_0077) begin nFail++; $display("FAIL nto_data got %h want 77", respData[63:32]); end
`endif
        idleInputs();
    endtask

    task automatic test_reset_busy();
        doReset();
        reqValid = 2'b01; reqAddr[31:0] = 32'h0000_0100;
        step();
        nTests++; if (memValid !== 1'b1) begin nFail++; $display("FAIL rb_c1 got %b want 1", memValid); end
        step();
        reset = 1'b1;
        #1;
        nTests++; if ({memValid, memWrite, memAddr} !== '0) begin nFail++; $display("FAIL rb_mem got %b/%h want 0/0", memValid, memAddr); end
        nTests++; if ({respValid, respError, respData} !== '0) begin nFail++; $display("FAIL rb_resp got %b/%b/%h want 0", respValid, respError, respData); end
        step();
        reset = 1'b0;
        reqAddr[31:0] = 32'h0000_0300; memReady = 1'b1; memRdata = 32'hCAFE_F00D;
        step();
        nTests++; if ({memValid, respValid, memAddr} !== {3'b100, 32'h0000_0300}) begin nFail++; $display("FAIL rb_new_c1 got %b/%b/%h want 1/00/00000300", memValid, respValid, memAddr); end
        step();
        nTests++; if ({respValid, respData[31:0]} !== {2'b01, 32'hCAFE_F00D}) begin nFail++; $display("FAIL rb_new_c2 got %b/%h want 01/cafef00d", respValid, respData[31:0]); end
        idleInputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idleInputs();
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_contention();
        test_parallel();
        test_write_wait();
        test_back_to_back();
        test_timeout();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mmu_port_router.md
# mmu_port_router

Parametrised memory-management router for NUM_PORTS requester ports. Each port issues one transaction at a time. Bit ADDR_WIDTH-1 of the address routes the transaction to one of two downstream targets: the memory/cache side (0) or the peripheral side (1). Each target has its own round-robin arbiter and a three-state handshake FSM, so one memory and one peripheral transaction can be in flight at once. The block sits between the core's fetch and data ports and the L1 caches and peripheral handler.

## Interface
- NUM_PORTS, 2: number of requester ports (1..8).
- ADDR_WIDTH, 32: address width; MSB selects the target.
- DATA_WIDTH, 32: data width.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; used only with MMU_TIMEOUT_EN.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqValid  in  NUM_PORTS  per-port request level; held until that port's respValid.
- reqWrite  in  NUM_PORTS  1 = write, 0 = read.
- reqAddr  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i occupies slice i.
- reqData  in  NUM_PORTS*DATA_WIDTH  packed write data.
- respValid  out  NUM_PORTS  one-cycle completion pulse.
- respData  out  NUM_PORTS*DATA_WIDTH  read data, valid while respValid is high.
- respError  out  NUM_PORTS  timeout flag, valid while respValid is high.
- memValid, memWrite  out  1  memory-target request and direction.
- memAddr  out  ADDR_WIDTH  memory-target address.
- memWdata  out  DATA_WIDTH  memory-target write data.
- memReady  in  1  memory-target completion.
- memRdata  in  DATA_WIDTH  memory-target read data.
- perValid, perWrite, perAddr, perWdata, perReady, perRdata: same set of signals for the peripheral target.

## Operation
- Routing: target = reqAddr[i][ADDR_WIDTH-1]. The address is passed through unmodified.
- Per-target FSM states and transitions:
  - IDLE: if any port has reqValid with an address on this target, register the round-robin grant, latch that port's index, write flag, address and data, then go to BUSY.
  - BUSY: valid is held high with the latched fields. When ready is sampled high, capture rdata (0 for writes) and go to DONE.
  - DONE: assert respValid[grant] with the captured data for exactly one cycle. No arbitration takes place in this state. Go to IDLE.
- Round-robin: the pointer starts at 0. The search runs ascending from the pointer and wraps at NUM_PORTS. After a grant, the pointer becomes grant+1 (mod NUM_PORTS). Each target keeps its own pointer.
- Outstanding requests: a port has at most one request outstanding, so a port is never granted by both targets. Responses from the two targets to different ports may occur in the same cycle.
- Request changes while waiting: reqAddr, reqWrite and reqData are sampled only at grant. Changes after the grant are ignored.
- Reset, at any time including mid-BUSY:
  - all FSMs go to IDLE and both pointers to 0;
  - respValid, respData, respError, memValid/perValid, memWrite/perWrite, addr and wdata outputs all go to 0;
  - an in-flight downstream transaction is abandoned with no response.

## Timing
- Request sampled high in cycle 0 (FSM in IDLE):
  - valid and the latched fields are driven from cycle 1;
  - with ready high in cycle 1, respValid is high in cycle 2.
- Minimum latency is 2 cycles. Peak throughput is one transaction per 3 cycles per target.
- Each additional cycle of ready-low adds one cycle of latency.
- The requester keeps reqValid high through the respValid cycle. A reqValid sampled in the cycle after respValid is treated as a new request.
- All outputs are registered. No combinational path from ready to respValid.

## Configuration
- MMU_TIMEOUT_EN defined:
  - a per-target counter runs in BUSY;
  - if ready is still low after TIMEOUT_CYCLES BUSY cycles, the FSM goes to DONE with respError=1, respData=0, and valid deasserted.
- MMU_TIMEOUT_EN undefined: respError is tied to 0, no counter exists, and BUSY waits indefinitely.

## Structure
- Package mmu_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - target constants TGT_MEM=0, TGT_PERIPH=1;
  - counter-width function $clog2(TIMEOUT_CYCLES+1).
- Sub-module rr_arbiter(NUM_PORTS): request vector plus pointer in, one-hot grant and index out, purely combinational. It is instantiated twice, once per target.

## Test plan
- Single memory read: port0 reads 0x00000100, memReady high, memRdata 0xDEADBEEF -> memValid high in cycle 1 with memAddr 0x100; respValid[0] high in cycle 2 with 0xDEADBEEF; respError 0.
- Contention: ports 0 and 1 read memory in the same cycle, pointer 0 -> port0 served first, port1 granted in the IDLE cycle after DONE; pointer ends at 0.
- Parallel targets: port0 reads 0x00000010 and port1 reads 0x80000004, both ready immediately -> memValid and perValid both high in cycle 1; respValid = 2'b11 in cycle 2.
- Write with wait: port1 writes 0x12345678 to 0x00000200, memReady asserted in cycle 3 -> memWrite=1 and memWdata=0x12345678 held in cycles 1-3; respValid[1] in cycle 4 with respData 0.
- Timeout (MMU_TIMEOUT_EN, TIMEOUT_CYCLES=255): perReady held low -> perValid high in cycles 1-255; respValid[1] with respError[1]=1 in cycle 256.
- Reset in BUSY: assert reset in cycle 2 of a memory read -> memValid and all resp outputs are 0 immediately, before the next edge; a new request after reset completes normally.
